// File: rtl/mem_arbiter_rr.sv
// N-channel memory request arbiter onto a single bus master port.
// One transaction in flight; the response is routed back to the owning channel and can be flushed.
module mem_arbiter_rr #(
  parameter int NUM_CH     = 2,
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int ID_W       = 4,
  parameter int FIXED_PRIO = 0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        req_valid,
  output logic [NUM_CH-1:0]        req_ready,
  input  logic [NUM_CH*ADDR_W-1:0] req_addr,
  input  logic [NUM_CH*DATA_W-1:0] req_wdata,
  input  logic [NUM_CH*2-1:0]      req_size,
  input  logic [NUM_CH-1:0]        req_wr,
  input  logic [NUM_CH-1:0]        flush,
  output logic [NUM_CH-1:0]        rsp_valid,
  input  logic [NUM_CH-1:0]        rsp_ready,
  output logic [DATA_W-1:0]        rsp_data,
  output logic                     bus_valid,
  input  logic                     bus_ready,
  output logic [ADDR_W-1:0]        bus_addr,
  output logic [DATA_W-1:0]        bus_wdata,
  output logic [1:0]               bus_size,
  output logic                     bus_wr,
  output logic [ID_W-1:0]          bus_id,
  input  logic                     bus_rsp_valid,
  input  logic [ID_W-1:0]          bus_rsp_id,
  input  logic [DATA_W-1:0]        bus_rsp_data,
  output logic                     err_id
);
  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_WAIT, S_RESP} state_t;
  state_t state, state_d;

  logic [PTR_W-1:0]  ptr;
  logic              drop;
  logic [NUM_CH-1:0] own;        // one-hot owner of the in-flight transaction
  logic [NUM_CH-1:0] req_eff;
  logic [NUM_CH-1:0] grant;
  logic [PTR_W-1:0]  win;
  logic              any_req;
  logic              accept;
  logic              flush_own;
  logic              rsp_hit;
  int                idx;

  // Flushed channels are removed from arbitration so another requester can win.
  always_comb begin
    req_eff = req_valid & ~flush;
    any_req = |req_eff;
    win     = '0;
    grant   = '0;
    idx     = 0;
    if (FIXED_PRIO != 0) begin
      for (int i = 0; i < NUM_CH; i++)
        if (req_eff[i]) win = PTR_W'(i);
    end else begin
      // Descending scan so the channel closest to ptr is assigned last and wins.
      for (int k = NUM_CH - 1; k >= 0; k--) begin
        idx = int'(ptr) + k;
        if (idx >= NUM_CH) idx = idx - NUM_CH;
        if (req_eff[idx]) win = PTR_W'(idx);
      end
    end
    grant[win] = any_req;
  end

  assign accept    = (state == S_IDLE) && any_req;
  assign req_ready = (state == S_IDLE) ? grant : '0;
  assign flush_own = |(flush & own);
  assign rsp_hit   = bus_rsp_valid && (state == S_WAIT) && (bus_rsp_id == bus_id);
  assign bus_valid = (state == S_ADDR);
  assign rsp_valid = (state == S_RESP) ? (own & ~flush) : '0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE: if (any_req) state_d = S_ADDR;
      S_ADDR: if (bus_ready) state_d = S_WAIT;
      S_WAIT: if (rsp_hit) state_d = (drop || flush_own) ? S_IDLE : S_RESP;
      S_RESP: if (flush_own || |(rsp_ready & own)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr       <= '0;
      drop      <= 1'b0;
      own       <= '0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_size  <= '0;
      bus_wr    <= 1'b0;
      bus_id    <= '0;
      rsp_data  <= '0;
      err_id    <= 1'b0;
    end else begin
      if (accept) begin
        own       <= grant;
        drop      <= 1'b0;
        bus_addr  <= req_addr[int'(win)*ADDR_W +: ADDR_W];
        bus_wdata <= req_wdata[int'(win)*DATA_W +: DATA_W];
        bus_size  <= req_size[int'(win)*2 +: 2];
        bus_wr    <= req_wr[win];
        bus_id    <= ID_W'(win);
        if (FIXED_PRIO == 0)
          ptr <= (win == PTR_W'(NUM_CH - 1)) ? '0 : win + 1'b1;
      end
      if ((state == S_ADDR || state == S_WAIT) && flush_own) drop <= 1'b1;
      // The bus still completes a flushed transaction; its response is swallowed here.
      if (rsp_hit) begin
        drop <= 1'b0;
        if (!(drop || flush_own)) rsp_data <= bus_rsp_data;
      end
      if (bus_rsp_valid && !rsp_hit) err_id <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Directed bench for mem_arbiter_rr: a round-robin instance driven by hand and a
// fixed-priority instance sharing the request side with an automatic bus responder.
module tb_mem_arbiter_rr;
  localparam int N = 3;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic [N-1:0]    req_valid = '0;
  logic [N*64-1:0] req_addr  = '0;
  logic [N*64-1:0] req_wdata = '0;
  logic [N*2-1:0]  req_size  = '0;
  logic [N-1:0]    req_wr    = '0;
  logic [N-1:0]    flush     = '0;

  // main instance
  logic [N-1:0] req_ready, rsp_valid, rsp_ready;
  logic [63:0]  rsp_data, bus_addr, bus_wdata;
  logic         bus_valid, bus_ready, bus_wr, bus_rsp_valid, err_id;
  logic [1:0]   bus_size;
  logic [3:0]   bus_id, bus_rsp_id;
  logic         auto_m = 1'b0, m_bus_ready = 1'b0, m_rsp_v = 1'b0;
  logic [3:0]   m_rsp_id = '0;
  logic [63:0]  m_rsp_data = '0;
  logic [N-1:0] m_rsp_ready = '0;
  logic         a_v = 1'b0;
  logic [3:0]   a_id = '0;

  assign bus_ready     = auto_m ? 1'b1 : m_bus_ready;
  assign bus_rsp_valid = auto_m ? a_v  : m_rsp_v;
  assign bus_rsp_id    = auto_m ? a_id : m_rsp_id;
  assign rsp_ready     = auto_m ? '1   : m_rsp_ready;

  always @(posedge clock) begin
    a_v  <= bus_valid & bus_ready;
    a_id <= bus_id;
  end

  mem_arbiter_rr #(.NUM_CH(N), .ADDR_W(64), .DATA_W(64), .ID_W(4), .FIXED_PRIO(0)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size), .req_wr(req_wr),
    .flush(flush), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_size(bus_size), .bus_wr(bus_wr), .bus_id(bus_id), .bus_rsp_valid(bus_rsp_valid),
    .bus_rsp_id(bus_rsp_id), .bus_rsp_data(m_rsp_data), .err_id(err_id));

  // fixed-priority instance, always serviced by its responder
  logic [N-1:0] f_req_ready, f_rsp_valid;
  logic [63:0]  f_rsp_data, f_bus_addr, f_bus_wdata;
  logic         f_bus_valid, f_bus_wr, f_err_id;
  logic [1:0]   f_bus_size;
  logic [3:0]   f_bus_id;
  logic         f_v = 1'b0;
  logic [3:0]   f_id = '0;
  logic [N-1:0] f_rsp_ready = '1;
  logic [63:0]  f_rsp_in = 64'h0;

  always @(posedge clock) begin
    f_v  <= f_bus_valid;
    f_id <= f_bus_id;
  end

  mem_arbiter_rr #(.NUM_CH(N), .ADDR_W(64), .DATA_W(64), .ID_W(4), .FIXED_PRIO(1)) dutf (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(f_req_ready),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size), .req_wr(req_wr),
    .flush(flush), .rsp_valid(f_rsp_valid), .rsp_ready(f_rsp_ready), .rsp_data(f_rsp_data),
    .bus_valid(f_bus_valid), .bus_ready(1'b1), .bus_addr(f_bus_addr), .bus_wdata(f_bus_wdata),
    .bus_size(f_bus_size), .bus_wr(f_bus_wr), .bus_id(f_bus_id), .bus_rsp_valid(f_v),
    .bus_rsp_id(f_id), .bus_rsp_data(f_rsp_in), .err_id(f_err_id));

  // grant logs
  logic      log_en = 1'b0;
  logic [3:0] log_m[$];
  logic [3:0] log_f[$];
  always @(posedge clock) if (log_en) begin
    if (bus_valid && bus_ready) log_m.push_back(bus_id);
    if (f_bus_valid)            log_f.push_back(f_bus_id);
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
  endtask

  typedef struct {
    logic [N-1:0] rv;
    logic [N-1:0] fl;
    logic [N-1:0] exp_rr;
    logic [N-1:0] exp_fx;
  } arb_vec_t;

  arb_vec_t vecs[8];

  initial begin
    vecs[0] = '{3'b000, 3'b000, 3'b000, 3'b000};
    vecs[1] = '{3'b111, 3'b000, 3'b001, 3'b100};
    vecs[2] = '{3'b110, 3'b000, 3'b010, 3'b100};
    vecs[3] = '{3'b100, 3'b000, 3'b100, 3'b100};
    vecs[4] = '{3'b011, 3'b000, 3'b001, 3'b010};
    vecs[5] = '{3'b101, 3'b001, 3'b100, 3'b100};
    vecs[6] = '{3'b111, 3'b111, 3'b000, 3'b000};
    vecs[7] = '{3'b111, 3'b100, 3'b001, 3'b010};

    // reset state
    tick();
    chk("rst_bus_valid", bus_valid, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_err_id", err_id, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_bus_id", bus_id, 0);
    chk("rst_rsp_data", rsp_data, 0);
    reset = 1'b1;
    tick();

    // combinational arbitration from ptr=0, requests withdrawn before each edge
    for (int i = 0; i < 8; i++) begin
      req_valid = vecs[i].rv;
      flush     = vecs[i].fl;
      #1;
      chk($sformatf("arb_rr_%0d", i), req_ready, vecs[i].exp_rr);
      chk($sformatf("arb_fx_%0d", i), f_req_ready, vecs[i].exp_fx);
      req_valid = '0;
      flush     = '0;
      tick();
    end

    // continuous requests: grant order
    auto_m = 1'b1; log_en = 1'b1; req_valid = 3'b111;
    for (int c = 0; c < 80 && (log_m.size() < 6 || log_f.size() < 3); c++) tick();
    req_valid = '0; log_en = 1'b0; auto_m = 1'b0;
    chk("rr_log_size", log_m.size() >= 6, 1);
    chk("fx_log_size", log_f.size() >= 3, 1);
    for (int i = 0; i < 6; i++)
      chk($sformatf("rr_order_%0d", i), (i < log_m.size()) ? log_m[i] : 4'hF, i % 3);
    for (int i = 0; i < 3; i++)
      chk($sformatf("fx_order_%0d", i), (i < log_f.size()) ? log_f[i] : 4'hF, 2);
    chk("rr_no_err", err_id, 0);
    do_reset();

    // single read on ch0
    req_addr[0 +: 64] = 64'h8000_0000; req_size[1:0] = 2'd2; req_wr[0] = 1'b0;
    req_valid = 3'b001;
    #1 chk("rd_req_ready", req_ready, 3'b001);
    tick();
    req_valid = '0;
    chk("rd_bus_valid", bus_valid, 1);
    chk("rd_bus_addr", bus_addr, 64'h8000_0000);
    chk("rd_bus_size", bus_size, 2);
    chk("rd_bus_wr", bus_wr, 0);
    chk("rd_bus_id", bus_id, 0);
    m_bus_ready = 1'b1;
    tick();
    m_bus_ready = 1'b0;
    chk("rd_wait_no_valid", bus_valid, 0);
    tick();
    m_rsp_v = 1'b1; m_rsp_id = 4'd0; m_rsp_data = 64'h1234_5678;
    tick();
    m_rsp_v = 1'b0;
    chk("rd_rsp_valid", rsp_valid, 3'b001);
    chk("rd_rsp_data", rsp_data, 64'h1234_5678);
    m_rsp_ready = 3'b001;
    tick();
    m_rsp_ready = '0;
    chk("rd_done", rsp_valid, 0);

    // write on ch1 with a stalled bus (ptr now 1)
    req_addr[64 +: 64] = 64'h0000_1000; req_wdata[64 +: 64] = 64'hDEAD_BEEF;
    req_size[3:2] = 2'd3; req_wr[1] = 1'b1;
    req_valid = 3'b010;
    #1 chk("wr_req_ready", req_ready, 3'b010);
    tick();
    req_valid = '0;
    req_wdata[64 +: 64] = 64'h0; req_addr[64 +: 64] = 64'h0;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("wr_hold_valid_%0d", c), bus_valid, 1);
      chk($sformatf("wr_hold_wdata_%0d", c), bus_wdata, 64'hDEAD_BEEF);
      chk($sformatf("wr_hold_addr_%0d", c), bus_addr, 64'h1000);
      chk($sformatf("wr_hold_wr_%0d", c), bus_wr, 1);
      tick();
    end
    chk("wr_bus_size", bus_size, 3);
    chk("wr_bus_id", bus_id, 1);
    m_bus_ready = 1'b1;
    tick();
    m_bus_ready = 1'b0;
    m_rsp_v = 1'b1; m_rsp_id = 4'd1; m_rsp_data = 64'h0;
    tick();
    m_rsp_v = 1'b0;
    chk("wr_rsp_valid", rsp_valid, 3'b010);
    m_rsp_ready = 3'b010;
    tick();
    m_rsp_ready = '0;
    req_wr[1] = 1'b0;

    // flush in WAIT for ch1 (ptr now 2, ch1 alone)
    req_valid = 3'b010;
    tick();
    req_valid = '0;
    m_bus_ready = 1'b1;
    tick();
    m_bus_ready = 1'b0;
    flush = 3'b010;
    tick();
    flush = '0;
    m_rsp_v = 1'b1; m_rsp_id = 4'd1; m_rsp_data = 64'h5555;
    req_valid = 3'b001;
    #1 chk("fl_wait_no_ready", req_ready, 0);
    tick();
    m_rsp_v = 1'b0;
    chk("fl_no_rsp", rsp_valid, 0);
    #1 chk("fl_next_grant", req_ready, 3'b001);
    tick();
    req_valid = '0;
    chk("fl_ch0_bus_id", bus_id, 0);
    m_bus_ready = 1'b1;
    tick();
    m_bus_ready = 1'b0;
    m_rsp_v = 1'b1; m_rsp_id = 4'd0; m_rsp_data = 64'hA5;
    tick();
    m_rsp_v = 1'b0;
    chk("fl_ch0_rsp", rsp_valid, 3'b001);
    chk("fl_ch0_data", rsp_data, 64'hA5);
    m_rsp_ready = 3'b001;
    tick();
    m_rsp_ready = '0;

    // wrong ID while waiting for ch1, then correct one; flush in RESP
    req_valid = 3'b010;
    tick();
    req_valid = '0;
    m_bus_ready = 1'b1;
    tick();
    m_bus_ready = 1'b0;
    m_rsp_v = 1'b1; m_rsp_id = 4'd3; m_rsp_data = 64'hBAD;
    tick();
    m_rsp_v = 1'b0;
    chk("err_set", err_id, 1);
    chk("err_no_rsp", rsp_valid, 0);
    m_rsp_v = 1'b1; m_rsp_id = 4'd1; m_rsp_data = 64'hCAFE;
    tick();
    m_rsp_v = 1'b0;
    chk("err_good_rsp", rsp_valid, 3'b010);
    chk("err_good_data", rsp_data, 64'hCAFE);
    chk("err_sticky", err_id, 1);
    flush = 3'b010;
    #1 chk("resp_flush_mask", rsp_valid, 0);
    tick();
    flush = '0;
    req_valid = 3'b100;
    #1 chk("resp_flush_idle", req_ready, 3'b100);
    tick();
    req_valid = '0;

    // async reset in ADDR
    chk("rst_addr_busy", bus_valid, 1);
    #2 reset = 1'b0;
    #1;
    chk("arst_bus_valid", bus_valid, 0);
    chk("arst_bus_addr", bus_addr, 0);
    chk("arst_err", err_id, 0);
    chk("arst_rsp_valid", rsp_valid, 0);
    tick();
    reset = 1'b1;
    req_valid = 3'b111;
    #1 chk("arst_ptr0", req_ready, 3'b001);
    req_valid = '0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_arbiter_rr.md
# mem_arbiter_rr

Parametrised N-channel bus arbiter between the CPU's memory requesters (instruction fetch, load/store, and future requesters) and the single AXI-side master port. It grants one requester at a time, either round-robin or fixed-priority, and tags the bus request with the winning channel's ID. It then routes the returning read data or write acknowledgement back to that channel over a valid/ready handshake. A per-channel flush discards an in-flight response without stalling the bus.

## Interface
Parameters:
- NUM_CH, 2, number of requester channels (2..8); channel index = ID
- ADDR_W, 64, address width
- DATA_W, 64, read/write data width
- ID_W, 4, bus ID width; must satisfy 2^ID_W >= NUM_CH
- FIXED_PRIO, 0, 0 = round-robin; 1 = fixed priority, highest index wins

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  reset; asynchronous, active-low
- req_valid  in  NUM_CH  per-channel request valid
- req_ready  out  NUM_CH  per-channel request accepted
- req_addr  in  NUM_CH*ADDR_W  packed addresses, channel i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_CH*DATA_W  packed store data
- req_size  in  NUM_CH*2  packed size, 0=1B 1=2B 2=4B 3=8B
- req_wr  in  NUM_CH  1 = write, 0 = read
- flush  in  NUM_CH  drop the pending response of that channel
- rsp_valid  out  NUM_CH  response valid, at most one bit set
- rsp_ready  in  NUM_CH  channel consumes response
- rsp_data  out  DATA_W  response data, shared by all channels
- bus_valid  out  1  request to bus
- bus_ready  in  1  bus accepts request
- bus_addr  out  ADDR_W  latched address
- bus_wdata  out  DATA_W  latched store data
- bus_size  out  2  latched size
- bus_wr  out  1  latched write flag
- bus_id  out  ID_W  granted channel index, zero-extended
- bus_rsp_valid  in  1  bus response strobe, single cycle
- bus_rsp_id  in  ID_W  response ID
- bus_rsp_data  in  DATA_W  read data; don't-care for writes
- err_id  out  1  sticky flag: response with unexpected ID or in wrong state

## Operation
- FSM with four states:
  - IDLE: arbitrate among req_valid.
  - ADDR: bus_valid=1 until bus_ready.
  - WAIT: await bus_rsp_valid with bus_rsp_id == latched ID.
  - RESP: rsp_valid[id]=1 until rsp_ready[id].
- Only one transaction is in flight at any time.
- Arbitration in IDLE:
  - Round-robin: scan from pointer ptr upward, with wrap-around; ptr advances to winner+1 mod NUM_CH on accept.
  - Fixed priority: highest set index wins; ptr unused.
- req_ready[w] = (state==IDLE) & winner==w; all other bits are 0. Combinational from req_valid.
- On accept: latch addr/wdata/size/wr/ID of the winner and go to ADDR.
- ADDR: on bus_ready, go to WAIT. The bus_* outputs stay stable while bus_valid=1.
- WAIT: on bus_rsp_valid with matching ID:
  - drop=0: latch bus_rsp_data into rsp_data and go to RESP.
  - drop=1: go to IDLE and clear drop.
- WAIT with non-matching ID, or bus_rsp_valid in IDLE/ADDR/RESP: response ignored, err_id set. err_id is cleared only by reset.
- RESP: on rsp_ready[id], go to IDLE.
- Flush rules:
  - flush[id] in ADDR or WAIT: set drop. The transaction still completes on the bus.
  - flush[id] in RESP: rsp_valid drops the same cycle (combinational mask); go to IDLE.
  - flush of a channel not currently owning the FSM: no effect.
  - flush[w] in IDLE suppresses that channel's req_ready that cycle.
- Simultaneous events:
  - Flush and matching response in the same WAIT cycle: response is dropped.
  - Flush and rsp_ready in the same RESP cycle: go to IDLE, no handshake counted.
- Reset (any time, including mid-transaction) clears everything immediately:
  - state=IDLE, ptr=0, drop=0, err_id=0
  - bus_valid=0, bus_addr/wdata/size/wr/id=0
  - rsp_valid=0, rsp_data=0

## Timing
- Accept at cycle T (req_valid & req_ready) -> bus_valid=1 at T+1.
- bus_ready sampled at edge E -> WAIT from E.
- bus_rsp_valid with matching ID at cycle R -> rsp_valid at R+1, with rsp_data registered.
- rsp_ready at cycle C -> IDLE at C+1; next accept is possible at C+1.
- Minimum turnaround, zero-wait bus: accept T, bus handshake T+1, response T+2, rsp_valid T+3, next accept T+4.
- All outputs are registered except req_ready and the flush mask on rsp_valid.

## Test plan
- Single read, ch0: addr 0x8000_0000, size 2, bus_ready at T+1, response id 0 data 0x1234_5678 at T+3 -> rsp_valid[0] at T+4, rsp_data=0x1234_5678, bus_id=0, bus_wr=0.
- Round-robin, NUM_CH=3, all channels valid continuously -> grant order 0,1,2,0,1,2; with FIXED_PRIO=1 -> 2,2,2.
- Write from ch1: wdata 0xDEAD_BEEF, size 3 -> bus_wr=1, bus_wdata and bus_addr held stable through 4 cycles of bus_ready=0; response returned to ch1.
- Flush in WAIT for ch1 -> matching response produces no rsp_valid, FSM back to IDLE; a following ch0 request is granted on the next cycle.
- Response with bus_rsp_id=3 while waiting for id 1 -> ignored, err_id=1 and stays set; the correct id 1 response later is delivered normally.
- Reset (reset=0) asserted in ADDR with bus_valid=1 -> bus_valid, rsp_valid, and state cleared asynchronously; after release, ptr=0 and ch0 wins first.
